// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline-side signals of the hazard control unit
interface hazard_control_unit_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 16
);
   logic                  de_mem_read_en_i;
   logic [ADDR_WIDTH-1:0] de_reg_dest_addr_i;
   logic                  dec_is_valid_i;
   logic [2:0]            dec_src_used_i;
   logic [ADDR_WIDTH-1:0] dec_reg_1_source_addr_i;
   logic [ADDR_WIDTH-1:0] dec_reg_2_source_addr_i;
   logic [ADDR_WIDTH-1:0] dec_reg_3_source_addr_i;
   logic                  branch_ex_i;
   logic                  branch_from_wb_i;
   logic                  stall_fetch_o;
   logic                  stall_decode_o;
   logic                  hazard_invalidate_o;
   logic                  flush_pipeline_o;
   logic [CNT_WIDTH-1:0]  stall_count_o;
   logic [CNT_WIDTH-1:0]  flush_count_o;

   modport master (
      output de_mem_read_en_i, de_reg_dest_addr_i, dec_is_valid_i, dec_src_used_i,
             dec_reg_1_source_addr_i, dec_reg_2_source_addr_i, dec_reg_3_source_addr_i,
             branch_ex_i, branch_from_wb_i,
      input  stall_fetch_o, stall_decode_o, hazard_invalidate_o, flush_pipeline_o,
             stall_count_o, flush_count_o
   );

   modport slave (
      input  de_mem_read_en_i, de_reg_dest_addr_i, dec_is_valid_i, dec_src_used_i,
             dec_reg_1_source_addr_i, dec_reg_2_source_addr_i, dec_reg_3_source_addr_i,
             branch_ex_i, branch_from_wb_i,
      output stall_fetch_o, stall_decode_o, hazard_invalidate_o, flush_pipeline_o,
             stall_count_o, flush_count_o
   );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use stall, branch flush sequencing and event counters
module hazard_control_unit #(
   parameter int ADDR_WIDTH   = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   hazard_control_unit_if.slave  hz
);
   typedef enum logic {IDLE, FLUSH} state_t;

   // Cycles still to hold after the one following the request.
   localparam logic [2:0] RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

   state_t         state_q, state_d;
   logic [2:0]     flush_cnt_q, flush_cnt_d;
   logic           load_use_hit;
   logic           flush_req;
   logic           flush_active;
   logic           stall;
   logic [CNT_WIDTH-1:0] stall_count_q;
   logic [CNT_WIDTH-1:0] flush_count_q;

   always_comb begin
      load_use_hit = hz.de_mem_read_en_i & hz.dec_is_valid_i &
                     ((hz.dec_src_used_i[0] & (hz.dec_reg_1_source_addr_i == hz.de_reg_dest_addr_i)) |
                      (hz.dec_src_used_i[1] & (hz.dec_reg_2_source_addr_i == hz.de_reg_dest_addr_i)) |
                      (hz.dec_src_used_i[2] & (hz.dec_reg_3_source_addr_i == hz.de_reg_dest_addr_i)));
   end

   assign flush_req = hz.branch_ex_i | hz.branch_from_wb_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         flush_cnt_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         IDLE: begin
            if (flush_req && (FLUSH_CYCLES > 1)) begin
               state_d     = FLUSH;
               flush_cnt_d = RELOAD;
            end
         end
         FLUSH: begin
            if (flush_req) begin
               flush_cnt_d = RELOAD;
            end else if (flush_cnt_q == 3'd0) begin
               state_d = IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Flush wins over stall: the flush already discards the dependent instruction.
   always_comb begin
      flush_active = ~reset_i & (flush_req | (state_q == FLUSH));
      stall        = ~reset_i & load_use_hit & ~flush_active;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         if (stall && (stall_count_q != '1))
            stall_count_q <= stall_count_q + CNT_WIDTH'(1);
         if (flush_req && (flush_count_q != '1))
            flush_count_q <= flush_count_q + CNT_WIDTH'(1);
      end
   end

   assign hz.stall_fetch_o       = stall;
   assign hz.stall_decode_o      = stall;
   assign hz.hazard_invalidate_o = stall;
   assign hz.flush_pipeline_o    = flush_active;
   assign hz.stall_count_o       = stall_count_q;
   assign hz.flush_count_o       = flush_count_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized and directed checks against a window-length model
module tb_hazard_control_unit;
   localparam int AW   = 4;
   localparam int FC_A = 2;
   localparam int CW_A = 4;
   localparam int FC_B = 5;
   localparam int CW_B = 16;

   logic clk;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   hazard_control_unit_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW_A)) ha ();
   hazard_control_unit_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW_B)) hb ();

   assign hb.de_mem_read_en_i        = ha.de_mem_read_en_i;
   assign hb.de_reg_dest_addr_i      = ha.de_reg_dest_addr_i;
   assign hb.dec_is_valid_i          = ha.dec_is_valid_i;
   assign hb.dec_src_used_i          = ha.dec_src_used_i;
   assign hb.dec_reg_1_source_addr_i = ha.dec_reg_1_source_addr_i;
   assign hb.dec_reg_2_source_addr_i = ha.dec_reg_2_source_addr_i;
   assign hb.dec_reg_3_source_addr_i = ha.dec_reg_3_source_addr_i;
   assign hb.branch_ex_i             = ha.branch_ex_i;
   assign hb.branch_from_wb_i        = ha.branch_from_wb_i;

   hazard_control_unit #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC_A), .CNT_WIDTH(CW_A)) dut_a (
      .clk_i(clk), .reset_i(rst), .hz(ha.slave));
   hazard_control_unit #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC_B), .CNT_WIDTH(CW_B)) dut_b (
      .clk_i(clk), .reset_i(rst), .hz(hb.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: remaining flush-window cycles after the current one, plus plain event counts.
   int left_a, left_b, scnt_a, scnt_b, fcnt_a, fcnt_b;

   function automatic bit m_hit();
      logic [AW-1:0] src [3];
      bit h = 0;
      src[0] = ha.dec_reg_1_source_addr_i;
      src[1] = ha.dec_reg_2_source_addr_i;
      src[2] = ha.dec_reg_3_source_addr_i;
      for (int k = 0; k < 3; k++)
         if (ha.dec_src_used_i[k] && src[k] == ha.de_reg_dest_addr_i) h = 1;
      return h && ha.de_mem_read_en_i && ha.dec_is_valid_i;
   endfunction

   function automatic bit m_req();
      return ha.branch_ex_i || ha.branch_from_wb_i;
   endfunction

   function automatic int sat_inc(int v, int max);
      return (v >= max) ? max : v + 1;
   endfunction

   always @(posedge clk or posedge rst) begin
      bit req, h, fa, fb;
      if (rst) begin
         left_a = 0; left_b = 0; scnt_a = 0; scnt_b = 0; fcnt_a = 0; fcnt_b = 0;
      end else begin
         req = m_req();
         h   = m_hit();
         fa  = req || left_a > 0;
         fb  = req || left_b > 0;
         if (h && !fa) scnt_a = sat_inc(scnt_a, (1 << CW_A) - 1);
         if (h && !fb) scnt_b = sat_inc(scnt_b, (1 << CW_B) - 1);
         if (req) begin
            fcnt_a = sat_inc(fcnt_a, (1 << CW_A) - 1);
            fcnt_b = sat_inc(fcnt_b, (1 << CW_B) - 1);
         end
         left_a = req ? FC_A - 1 : (left_a > 0 ? left_a - 1 : 0);
         left_b = req ? FC_B - 1 : (left_b > 0 ? left_b - 1 : 0);
      end
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      bit fa, fb, sa, sb;
      fa = !rst && (m_req() || left_a > 0);
      fb = !rst && (m_req() || left_b > 0);
      sa = !rst && m_hit() && !fa;
      sb = !rst && m_hit() && !fb;
      chk1("a_flush", ha.flush_pipeline_o, fa);
      chk1("a_stall_fetch", ha.stall_fetch_o, sa);
      chk1("a_stall_decode", ha.stall_decode_o, sa);
      chk1("a_invalidate", ha.hazard_invalidate_o, sa);
      chkn("a_stall_count", 32'(ha.stall_count_o), 32'(scnt_a));
      chkn("a_flush_count", 32'(ha.flush_count_o), 32'(fcnt_a));
      chk1("b_flush", hb.flush_pipeline_o, fb);
      chk1("b_invalidate", hb.hazard_invalidate_o, sb);
      chkn("b_stall_count", 32'(hb.stall_count_o), 32'(scnt_b));
      chkn("b_flush_count", 32'(hb.flush_count_o), 32'(fcnt_b));
   endtask

   always @(negedge clk) check_all();

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ha.de_mem_read_en_i        = 1'b0;
      ha.de_reg_dest_addr_i      = '0;
      ha.dec_is_valid_i          = 1'b0;
      ha.dec_src_used_i          = 3'b000;
      ha.dec_reg_1_source_addr_i = '0;
      ha.dec_reg_2_source_addr_i = '0;
      ha.dec_reg_3_source_addr_i = '0;
      ha.branch_ex_i             = 1'b0;
      ha.branch_from_wb_i        = 1'b0;
   endtask

   task automatic set_load_use();
      ha.de_mem_read_en_i        = 1'b1;
      ha.de_reg_dest_addr_i      = 4'd3;
      ha.dec_is_valid_i          = 1'b1;
      ha.dec_src_used_i          = 3'b010;
      ha.dec_reg_1_source_addr_i = 4'd5;
      ha.dec_reg_2_source_addr_i = 4'd3;
      ha.dec_reg_3_source_addr_i = 4'd7;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      set_load_use();
      ha.branch_ex_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("rst_flush", ha.flush_pipeline_o, 1'b0);
      chk1("rst_stall", ha.stall_fetch_o, 1'b0);
      chk1("rst_inv", ha.hazard_invalidate_o, 1'b0);
      chkn("rst_fcnt", 32'(ha.flush_count_o), 0);
      chkn("rst_scnt", 32'(ha.stall_count_o), 0);

      tick(); rst = 1'b0; ha.branch_ex_i = 1'b0;
      @(negedge clk);
      chk1("lu_fetch", ha.stall_fetch_o, 1'b1);
      chk1("lu_decode", ha.stall_decode_o, 1'b1);
      chk1("lu_inv", ha.hazard_invalidate_o, 1'b1);
      tick(); clear_inputs();
      @(negedge clk);
      chkn("lu_scnt", 32'(ha.stall_count_o), 1);
      tick(); set_load_use(); ha.dec_src_used_i = 3'b101;
      @(negedge clk);
      chk1("nolu_stall", ha.stall_fetch_o, 1'b0);

      tick(); clear_inputs(); ha.branch_ex_i = 1'b1;
      @(negedge clk);
      chk1("fl_c0", ha.flush_pipeline_o, 1'b1);
      tick(); ha.branch_ex_i = 1'b0;
      @(negedge clk);
      chk1("fl_c1", ha.flush_pipeline_o, 1'b1);
      chk1("fl_b_c1", hb.flush_pipeline_o, 1'b1);
      tick();
      @(negedge clk);
      chk1("fl_c2", ha.flush_pipeline_o, 1'b0);
      chk1("fl_b_c2", hb.flush_pipeline_o, 1'b1);
      chkn("fl_cnt", 32'(ha.flush_count_o), 1);
      repeat (3) tick();
      @(negedge clk);
      chk1("fl_b_c5", hb.flush_pipeline_o, 1'b0);

      tick(); set_load_use(); ha.branch_from_wb_i = 1'b1;
      @(negedge clk);
      chk1("rs_f0", ha.flush_pipeline_o, 1'b1);
      chk1("rs_s0", ha.stall_fetch_o, 1'b0);
      tick();
      @(negedge clk);
      chk1("rs_f1", ha.flush_pipeline_o, 1'b1);
      chk1("rs_s1", ha.hazard_invalidate_o, 1'b0);
      tick(); ha.branch_from_wb_i = 1'b0;
      @(negedge clk);
      chk1("rs_f2", ha.flush_pipeline_o, 1'b1);
      chk1("rs_s2", ha.hazard_invalidate_o, 1'b0);
      tick();
      @(negedge clk);
      chk1("rs_f3", ha.flush_pipeline_o, 1'b0);
      chk1("rs_s3", ha.stall_fetch_o, 1'b1);
      chkn("rs_fcnt", 32'(ha.flush_count_o), 3);
      chkn("rs_scnt", 32'(ha.stall_count_o), 1);

      tick(); clear_inputs(); ha.branch_ex_i = 1'b1;
      tick(); ha.branch_ex_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk1("rmf_a", ha.flush_pipeline_o, 1'b0);
      chk1("rmf_b", hb.flush_pipeline_o, 1'b0);
      tick(); rst = 1'b0;
      @(negedge clk);
      chk1("rmf_after_a", ha.flush_pipeline_o, 1'b0);
      chk1("rmf_after_b", hb.flush_pipeline_o, 1'b0);

      tick(); set_load_use();
      repeat (20) tick();
      @(negedge clk);
      chkn("sat_a", 32'(ha.stall_count_o), 15);
      chkn("sat_b", 32'(hb.stall_count_o), 20);

      repeat (3000) begin
         tick();
         rst                        = ($urandom_range(0, 99) == 0);
         ha.de_mem_read_en_i        = 1'($urandom_range(0, 1));
         ha.de_reg_dest_addr_i      = AW'($urandom_range(0, 3));
         ha.dec_is_valid_i          = ($urandom_range(0, 3) != 0);
         ha.dec_src_used_i          = 3'($urandom_range(0, 7));
         ha.dec_reg_1_source_addr_i = AW'($urandom_range(0, 3));
         ha.dec_reg_2_source_addr_i = AW'($urandom_range(0, 3));
         ha.dec_reg_3_source_addr_i = AW'($urandom_range(0, 3));
         ha.branch_ex_i             = ($urandom_range(0, 9) == 0);
         ha.branch_from_wb_i        = ($urandom_range(0, 11) == 0);
      end
      tick();
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
